input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer.sv | 109 ++++++++++
 tb/tb_input_debouncer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer
// Brief    : Four-state debouncer. w changes only after N_CYCLES consecutive
//            samples of the opposite level. Optional two-flop input
//            synchronizer is enabled with `define DEBOUNCE_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module input_debouncer #(
    parameter int unsigned N_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic w,
    output logic settling
);

    // Bit 1 of the encoding is the debounced level and bit 0 marks a candidate
    // change, so both outputs come straight from state flops.
    typedef enum logic [1:0] {
        LOW    = 2'b00,
        CHK_HI = 2'b01,
        HIGH   = 2'b10,
        CHK_LO = 2'b11
    } state_t;

    localparam logic [15:0] c_last = 16'(N_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        w_s;

`ifdef DEBOUNCE_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = din;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LOW;
            r_cnt   <= 16'd0;
        end else begin
            case (r_state)
                LOW: begin
                    if (w_s) begin
                        r_state <= CHK_HI;
                        r_cnt   <= 16'd1;
                    end else begin
                        r_cnt   <= 16'd0;
                    end
                end
                CHK_HI: begin
                    if (!w_s) begin
                        r_state <= LOW;
                        r_cnt   <= 16'd0;
                    end else if (r_cnt == c_last) begin
                        r_state <= HIGH;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt   <= r_cnt + 16'd1;
                    end
                end
                HIGH: begin
                    if (!w_s) begin
                        r_state <= CHK_LO;
                        r_cnt   <= 16'd1;
                    end else begin
                        r_cnt   <= 16'd0;
                    end
                end
                CHK_LO: begin
                    if (w_s) begin
                        r_state <= HIGH;
                        r_cnt   <= 16'd0;
                    end else if (r_cnt == c_last) begin
                        r_state <= LOW;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt   <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= LOW;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

    assign w        = r_state[1];
    assign settling = r_state[0];

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_debouncer
// Brief    : Scoreboard bench for input_debouncer against a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic din = 1'b0;
    logic w;
    logic settling;

    input_debouncer #(.N_CYCLES(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .w        (w),
        .settling (settling)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] exp_q[$];

    // Model: count how long the sample has differed from the accepted level;
    // once that run reaches N the accepted level flips.
    logic m_w = 1'b0;
    int   m_run = 0;
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    int   m_rises = 0;
    int   dut_rises = 0;

    task automatic step(input logic d, input logic r);
        logic s;
        @(negedge clk);
        din   = d;
        reset = r;
        if (r) begin
            m_w   = 1'b0;
            m_run = 0;
            m_s1  = 1'b0;
            m_s2  = 1'b0;
        end else begin
`ifdef DEBOUNCE_SYNC_EN
            s    = m_s2;
            m_s2 = m_s1;
            m_s1 = d;
`else
            s = d;
`endif
            if (s != m_w) begin
                m_run++;
                if (m_run == N) begin
                    m_w   = ~m_w;
                    m_run = 0;
                    if (m_w) m_rises++;
                end
            end else begin
                m_run = 0;
            end
        end
        exp_q.push_back({m_w, (m_run != 0)});
    endtask

    task automatic hold(input logic d, input int cycles);
        for (int i = 0; i < cycles; i++) step(d, 1'b0);
    endtask

    // Monitor: the debouncer presents a new output after every edge.
    initial begin : monitor
        logic [1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({w, settling} !== e) begin
                    n_fail++;
                    $display("FAIL out t=%0t w/settling got=%b%b expected=%b%b",
                             $time, w, settling, e[1], e[0]);
                end
            end
        end
    end

    // Downstream rising-edge detector on the debounced level.
    logic r_w_d = 1'b0;
    always @(posedge clk) begin
        r_w_d <= w;
        if (w && !r_w_d && !reset) dut_rises <= dut_rises + 1;
    end

    initial begin : stimulus
        int wait_cnt;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        hold(1'b0, 5);

        // Clean rise, held.
        hold(1'b1, 8);
        hold(1'b0, 8);
        // Short pulse of N-1 samples must be rejected.
        hold(1'b1, N - 1);
        hold(1'b0, 4);
        // Bounce then settle high.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        hold(1'b1, 6);
        // Start falling, reset mid-qualification, then re-qualify from scratch.
        hold(1'b0, 3);
        step(1'b0, 1'b1);
        hold(1'b1, 6);
        // Reset while qualifying high.
        hold(1'b0, 6);
        hold(1'b1, 2);
        step(1'b1, 1'b1);
        hold(1'b1, 6);
        hold(1'b0, 6);

        // Random bouncy bursts with occasional resets.
        for (int k = 0; k < 400; k++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(N, 2 * N + 3))
                                              : int'($urandom_range(1, N));
            for (int j = 0; j < len; j++)
                step(lvl, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end
        hold(1'b0, 10);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending got=%0d expected=0", exp_q.size());
        end
        n_tests++;
        if (dut_rises != m_rises) begin
            n_fail++;
            $display("FAIL rise_count got=%0d expected=%0d", dut_rises, m_rises);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
